// File: rtl/reg_serial_tx.sv
// reg_serial_tx: parallel-to-serial readout of a register word, LSB first,
// with valid/last framing and a shift-freeze input.
// Optional feature: define PARITY_EN to append one even-parity bit per frame.
module reg_serial_tx #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             SER_HOLD,
  output logic             SER_OUT,
  output logic             SER_VALID,
  output logic             SER_LAST,
  output logic             BUSY
);

`ifdef PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_out_q, ser_valid_q, ser_last_q, busy_q;
  logic             next_bit_d, next_last_d;
  logic             load_fire;
`ifdef PARITY_EN
  logic             parity_q;
`endif

  // Ready while idle, or on the final unheld bit so frames chain with no gap.
  assign LOAD_READY = ~RST & ((state_q == IDLE) |
                              ((state_q == SHIFT) & (cnt_q == LAST_IDX) & ~SER_HOLD));
  assign load_fire  = LOAD_VALID & LOAD_READY;

  // Next shift position and the bit/last flag that will be presented with it.
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    shift_d     = shift_q >> 1;
    next_bit_d  = shift_q[1];
`ifdef PARITY_EN
    // Data bits exhausted: the slot after them carries the stored parity.
    if (cnt_d == CW'(WIDTH)) next_bit_d = parity_q;
`endif
    next_last_d = (cnt_d == LAST_IDX);
  end

  // Frame FSM with registered serial outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the shift register is reset too, so an abandoned frame can never
      // leak old bits into a later one.
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else if (load_fire) begin
      state_q     <= SHIFT;
      shift_q     <= DATA_IN;
      cnt_q       <= '0;
      ser_out_q   <= DATA_IN[0];
      ser_valid_q <= 1'b1;
      ser_last_q  <= 1'b0;
      busy_q      <= 1'b1;
`ifdef PARITY_EN
      parity_q    <= ^DATA_IN;
`endif
    end else if ((state_q == SHIFT) && !SER_HOLD) begin
      if (cnt_q == LAST_IDX) begin
        state_q     <= IDLE;
        shift_q     <= '0;
        cnt_q       <= '0;
        ser_out_q   <= 1'b0;
        ser_valid_q <= 1'b0;
        ser_last_q  <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        shift_q     <= shift_d;
        cnt_q       <= cnt_d;
        ser_out_q   <= next_bit_d;
        ser_last_q  <= next_last_d;
      end
    end
  end

  assign SER_OUT   = ser_out_q;
  assign SER_VALID = ser_valid_q;
  assign SER_LAST  = ser_last_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_reg_serial_tx.sv
// Directed testbench for reg_serial_tx (WIDTH=8); parity steps run when
// PARITY_EN is defined.
module tb_reg_serial_tx;

`ifdef PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       LOAD_VALID = 1'b0;
  logic       LOAD_READY;
  logic [7:0] DATA_IN = 8'h00;
  logic       SER_HOLD = 1'b0;
  logic       SER_OUT, SER_VALID, SER_LAST, BUSY;

  int compared   = 0;
  int mismatched = 0;

  reg_serial_tx #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .DATA_IN(DATA_IN), .SER_HOLD(SER_HOLD), .SER_OUT(SER_OUT),
    .SER_VALID(SER_VALID), .SER_LAST(SER_LAST), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; inputs are driven, then outputs sampled.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected frame bit i for word w: data LSB first, then even parity.
  function automatic logic exp_bit(input logic [7:0] w, input int i);
    return (i < 8) ? w[i] : ^w;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, SER_VALID, 0);
    check({tag, "_last"},  SER_LAST,  0);
    check({tag, "_out"},   SER_OUT,   0);
    check({tag, "_busy"},  BUSY,      0);
  endtask

  // Load one word from idle and check every frame cycle plus the idle after.
  task automatic send_word(input string tag, input logic [7:0] w);
    LOAD_VALID = 1'b1;
    DATA_IN    = w;
    #1 check({tag, "_ready_idle"}, LOAD_READY, 1);
    step();
    LOAD_VALID = 1'b0;
    for (int i = 0; i < FL; i++) begin
      #1;
      check($sformatf("%s_bit%0d", tag, i), SER_OUT, exp_bit(w, i));
      check($sformatf("%s_valid%0d", tag, i), SER_VALID, 1);
      check($sformatf("%s_last%0d", tag, i), SER_LAST, (i == FL - 1));
      check($sformatf("%s_busy%0d", tag, i), BUSY, 1);
      step();
    end
    check_idle({tag, "_end"});
  endtask

  initial begin
    // Reset held 2 cycles with a load offered.
    RST = 1'b1; LOAD_VALID = 1'b1; DATA_IN = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      step();
      check_idle($sformatf("rst%0d", i));
      check($sformatf("rst%0d_ready", i), LOAD_READY, 0);
    end
    RST = 1'b0; LOAD_VALID = 1'b0;
    #1 check("post_rst_ready", LOAD_READY, 1);
    step();
    check("post_rst_valid", SER_VALID, 0);
    check("post_rst_ready2", LOAD_READY, 1);

    // Single word.
    send_word("a5", 8'hA5);

    // Back-to-back 01 then 80, LOAD_VALID held across the boundary.
    LOAD_VALID = 1'b1; DATA_IN = 8'h01;
    step();
    DATA_IN = 8'h80;
    for (int j = 0; j < 2 * FL; j++) begin
      #1;
      check($sformatf("b2b_bit%0d", j), SER_OUT,
            exp_bit((j < FL) ? 8'h01 : 8'h80, j % FL));
      check($sformatf("b2b_valid%0d", j), SER_VALID, 1);
      check($sformatf("b2b_last%0d", j), SER_LAST, (j == FL - 1) || (j == 2 * FL - 1));
      check($sformatf("b2b_ready%0d", j), LOAD_READY, (j == FL - 1) || (j == 2 * FL - 1));
      step();
      if (j == FL - 1) LOAD_VALID = 1'b0;
    end
    check_idle("b2b_end");

    // Hold for 3 edges while bit 3 of 3C is on the line.
    LOAD_VALID = 1'b1; DATA_IN = 8'h3C;
    step();
    LOAD_VALID = 1'b0;
    for (int c = 0; c < FL + 3; c++) begin
      automatic int b = (c < 3) ? c : (c < 7) ? 3 : c - 3;
      SER_HOLD = (c >= 3) && (c <= 5);
      #1;
      check($sformatf("hold_bit%0d", c), SER_OUT, exp_bit(8'h3C, b));
      check($sformatf("hold_valid%0d", c), SER_VALID, 1);
      check($sformatf("hold_last%0d", c), SER_LAST, (c == FL + 2));
      check($sformatf("hold_ready%0d", c), LOAD_READY, (c == FL + 2));
      step();
    end
    SER_HOLD = 1'b0;
    check_idle("hold_end");

    // Reset at bit 4 of FF, then a clean 00 frame.
    LOAD_VALID = 1'b1; DATA_IN = 8'hFF;
    step();
    LOAD_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ff_bit%0d", i), SER_OUT, 1);
      step();
    end
    check("ff_bit4", SER_OUT, 1);
    RST = 1'b1;
    step();
    check_idle("midrst");
    check("midrst_ready", LOAD_READY, 0);
    RST = 1'b0;
    send_word("zero", 8'h00);

`ifdef PARITY_EN
    send_word("par07", 8'h07);
    send_word("par03", 8'h03);
`endif

    // SER_HOLD in IDLE must not block a load.
    SER_HOLD = 1'b1;
    #1 check("idle_hold_ready", LOAD_READY, 1);
    SER_HOLD = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_serial_tx.md
# reg_serial_tx

Parallel-to-serial readout for the CPU's register bank. Each accepted parallel word is latched and shifted out one bit per clock, LSB first, on a single-bit serial line with valid/last framing. The block is the read-side counterpart of the 1-bit storage flops: it streams stored register contents to the debug/observation port without stalling the datapath.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32
- CLK  input  1  rising-edge clock
- RST  input  1  synchronous, active-high reset
- LOAD_VALID  input  1  DATA_IN is offered for transmission
- LOAD_READY  output  1  block accepts a word this cycle
- DATA_IN  input  WIDTH  parallel word to send
- SER_HOLD  input  1  freeze the shift; outputs held
- SER_OUT  output  1  current serial bit
- SER_VALID  output  1  SER_OUT carries a frame bit
- SER_LAST  output  1  SER_OUT is the final bit of the frame
- BUSY  output  1  frame in progress (state SHIFT)

## Operation
- States: IDLE, SHIFT. Reset forces IDLE.
- Load handshake: word accepted on a rising edge where LOAD_VALID & LOAD_READY. DATA_IN captured into shift register; bit counter cleared; state -> SHIFT.
- LOAD_READY = ~RST & (IDLE | (SHIFT & SER_LAST & ~SER_HOLD)). Combinational from state, counter and SER_HOLD.
- SHIFT: SER_VALID=1, SER_OUT = shift_reg[0]. Each edge with SER_HOLD=0: shift right by one, counter +1. Each edge with SER_HOLD=1: shift register, counter, SER_OUT, SER_VALID and SER_LAST unchanged.
- SER_LAST=1 when counter == FRAME_LEN-1. FRAME_LEN = WIDTH, or WIDTH+1 with parity (see Configuration).
- End of frame: on an edge with SER_LAST=1 and SER_HOLD=0:
  - with LOAD_VALID=1: new word is loaded and the block stays in SHIFT with no gap cycle;
  - otherwise: state -> IDLE.
- IDLE: SER_VALID=0, SER_LAST=0, SER_OUT=0, BUSY=0. SER_HOLD is ignored.
- LOAD_VALID while LOAD_READY=0 is ignored; the sender must hold it.
- Counter width is $clog2(WIDTH+2). No wrap is possible inside a frame.

## Timing
- Reset values, from the edge after RST=1: state IDLE, SER_OUT=0, SER_VALID=0, SER_LAST=0, BUSY=0, shift register 0, counter 0. LOAD_READY=0 while RST=1 and 1 in the first cycle after RST falls.
- RST=1 wins over every other input, including mid-frame. The frame is abandoned with no partial completion and no SER_LAST.
- Latency: word accepted at edge k → bit 0 on SER_OUT in cycle k+1 (registered output).
- Without holds, the last bit appears in cycle k+FRAME_LEN.
- Back-to-back throughput: one bit per clock, 100% SER_VALID duty.
- All outputs except LOAD_READY are registered.

## Configuration
- PARITY_EN defined:
  - FRAME_LEN = WIDTH+1;
  - after the WIDTH data bits, one even-parity bit (XOR of the captured word) is sent;
  - SER_LAST is asserted on the parity bit only;
  - parity is computed at load time and held in a dedicated flop.
- PARITY_EN undefined: FRAME_LEN = WIDTH, and no parity logic is generated.

## Test plan
- Reset: assert RST 2 cycles while LOAD_VALID=1 and DATA_IN=8'hFF → all outputs 0 and LOAD_READY=0 during reset. After release, LOAD_READY=1 and SER_VALID stays 0.
- Single word 8'hA5 (WIDTH=8, no PARITY_EN) → SER_OUT = 1,0,1,0,0,1,0,1 in cycles k+1..k+8. SER_LAST only in k+8, then IDLE with SER_VALID=0 in k+9.
- Back-to-back 8'h01 then 8'h80 with LOAD_VALID held → 16 contiguous SER_VALID cycles, bits 1,0×7,0×7,1. SER_LAST in cycles 8 and 16, and LOAD_READY pulses exactly at those cycles.
- SER_HOLD=1 for 3 cycles during bit 3 of 8'h3C → SER_OUT holds 1 for 1+3 cycles, the frame completes 3 cycles late, and the bit sequence is unchanged.
- RST asserted at bit 4 of 8'hFF → SER_VALID=0 on the next edge. A new 8'h00 load afterwards sends eight 0s with no leftover 1s.
- PARITY_EN with 8'h07 → data bits 1,1,1,0,0,0,0,0 then parity bit 1 in cycle k+9, with SER_LAST there only. With 8'h03 the parity bit is 0.
